// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants for the instruction fetch initiator:
//                FSM state encoding and insn_err_o result codes.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_bus  = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    // insn_err_o result codes
    localparam logic [1:0] c_err_ok       = 2'b00;
    localparam logic [1:0] c_err_bus      = 2'b01;
    localparam logic [1:0] c_err_timeout  = 2'b10;
    localparam logic [1:0] c_err_misalign = 2'b11;

    // Instructions are 32-bit words; the two low address bits must be zero.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : bus_watchdog
//  Description : Counts consecutive enabled cycles of a bus transaction and
//                flags expiry in the cycle that reaches TIMEOUT.
//  Ports       : clk        - clock
//                i_reset_n  - synchronous active-low reset
//                i_clear    - restart the count (new transaction accepted)
//                i_enable   - a bus cycle is in progress this cycle
//                o_expired  - this enabled cycle is cycle number TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // r_count holds the number of completed bus cycles, so the cycle in
    // progress is number r_count+1; expiry fires when that equals TIMEOUT.
    localparam logic [7:0] c_limit = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_enable && (r_count == c_limit);

endmodule : bus_watchdog
`default_nettype wire

// File: rtl/fetch_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_initiator
//  Description : Single-outstanding instruction fetch engine. Accepts a PC,
//                runs one strobe/acknowledge bus read with watchdog, and holds
//                the result (or error code) until the core consumes it.
//  Ports       : clk_i, reset_ni              - clock, sync active-low reset
//                pc_i, pc_valid_i, pc_ready_o - fetch request handshake
//                flush_i                      - abort fetch / drop result
//                iadr_o, istb_o               - bus address / strobe
//                iack_i, ierr_i, idat_i       - bus ack / error / read data
//                insn_o, insn_pc_o, insn_err_o,
//                insn_valid_o, insn_ready_i   - result handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_initiator
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] iadr_o,
    output logic              istb_o,
    input  logic              iack_i,
    input  logic              ierr_i,
    input  logic [31:0]       idat_i,
    output logic [31:0]       insn_o,
    output logic [ADDR_W-1:0] insn_pc_o,
    output logic [1:0]        insn_err_o,
    output logic              insn_valid_o,
    input  logic              insn_ready_i
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_iadr;
    logic              r_istb;
    logic [31:0]       r_insn;
    logic [ADDR_W-1:0] r_insn_pc;
    logic [1:0]        r_insn_err;
    logic              r_insn_valid;

    logic w_pc_ready;
    logic w_accept;
    logic w_in_bus;
    logic w_expired;

    // Ready is the only combinational output; it lets a consumed HOLD result
    // hand over straight to the next request without an IDLE bubble.
    assign w_pc_ready = reset_ni && !flush_i &&
                        ((r_state == c_st_idle) ||
                         ((r_state == c_st_hold) && insn_ready_i));
    assign w_accept   = pc_valid_i && w_pc_ready;
    assign w_in_bus   = (r_state == c_st_bus);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk_i),
        .i_reset_n (reset_ni),
        .i_clear   (w_accept),
        .i_enable  (w_in_bus),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state      <= c_st_idle;
            r_iadr       <= '0;
            r_istb       <= 1'b0;
            r_insn       <= 32'd0;
            r_insn_pc    <= '0;
            r_insn_err   <= c_err_ok;
            r_insn_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_bus: begin
                    // Flush wins over any same-cycle completion; error wins
                    // over acknowledge.
                    if (flush_i) begin
                        r_istb  <= 1'b0;
                        r_state <= c_st_idle;
                    end else if (ierr_i) begin
                        r_istb       <= 1'b0;
                        r_insn       <= 32'd0;
                        r_insn_err   <= c_err_bus;
                        r_insn_valid <= 1'b1;
                        r_state      <= c_st_hold;
                    end else if (iack_i) begin
                        r_istb       <= 1'b0;
                        r_insn       <= idat_i;
                        r_insn_err   <= c_err_ok;
                        r_insn_valid <= 1'b1;
                        r_state      <= c_st_hold;
                    end else if (w_expired) begin
                        r_istb       <= 1'b0;
                        r_insn       <= 32'd0;
                        r_insn_err   <= c_err_timeout;
                        r_insn_valid <= 1'b1;
                        r_state      <= c_st_hold;
                    end
                end
                default: begin
                    // IDLE and HOLD share the acceptance path; HOLD without
                    // acceptance either keeps its result or retires it.
                    if (w_accept) begin
                        r_insn_pc <= pc_i;
                        if (is_aligned(pc_i[1:0])) begin
                            r_iadr       <= pc_i;
                            r_istb       <= 1'b1;
                            r_insn_valid <= 1'b0;
                            r_state      <= c_st_bus;
                        end else begin
                            r_istb       <= 1'b0;
                            r_insn       <= 32'd0;
                            r_insn_err   <= c_err_misalign;
                            r_insn_valid <= 1'b1;
                            r_state      <= c_st_hold;
                        end
                    end else if ((r_state == c_st_hold) &&
                                 (flush_i || insn_ready_i)) begin
                        r_insn_valid <= 1'b0;
                        r_state      <= c_st_idle;
                    end
                end
            endcase
        end
    end

    assign pc_ready_o   = w_pc_ready;
    assign iadr_o       = r_iadr;
    assign istb_o       = r_istb;
    assign insn_o       = r_insn;
    assign insn_pc_o    = r_insn_pc;
    assign insn_err_o   = r_insn_err;
    assign insn_valid_o = r_insn_valid;

endmodule : fetch_initiator
`default_nettype wire

// File: tb/tb_fetch_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_initiator
//  Description : Directed self-checking bench for fetch_initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_initiator;

    localparam int ADDR_W  = 64;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_ni;
    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic              flush_i;
    logic [ADDR_W-1:0] iadr_o;
    logic              istb_o;
    logic              iack_i;
    logic              ierr_i;
    logic [31:0]       idat_i;
    logic [31:0]       insn_o;
    logic [ADDR_W-1:0] insn_pc_o;
    logic [1:0]        insn_err_o;
    logic              insn_valid_o;
    logic              insn_ready_i;

    int checks   = 0;
    int failures = 0;

    fetch_initiator #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .iadr_o       (iadr_o),
        .istb_o       (istb_o),
        .iack_i       (iack_i),
        .ierr_i       (ierr_i),
        .idat_i       (idat_i),
        .insn_o       (insn_o),
        .insn_pc_o    (insn_pc_o),
        .insn_err_o   (insn_err_o),
        .insn_valid_o (insn_valid_o),
        .insn_ready_i (insn_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset_ni     = 1'b0;
        pc_i         = '0;
        pc_valid_i   = 1'b0;
        flush_i      = 1'b0;
        iack_i       = 1'b0;
        ierr_i       = 1'b0;
        idat_i       = 32'd0;
        insn_ready_i = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_istb",   64'(istb_o), 64'd0);
        chk("rst_valid",  64'(insn_valid_o), 64'd0);
        chk("rst_err",    64'(insn_err_o), 64'd0);
        chk("rst_iadr",   iadr_o, 64'd0);
        chk("rst_ready",  64'(pc_ready_o), 64'd0);
        reset_ni = 1'b1;
        #1;
        chk("idle_ready", 64'(pc_ready_o), 64'd1);

        // Aligned fetch, ack in first strobe cycle, two-cycle latency
        pc_i = 64'h1000; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; iack_i = 1'b1; idat_i = 32'h0000_0013;
        chk("f1_istb",  64'(istb_o), 64'd1);
        chk("f1_iadr",  iadr_o, 64'h1000);
        chk("f1_valid", 64'(insn_valid_o), 64'd0);
        #1;
        chk("f1_busy_ready", 64'(pc_ready_o), 64'd0);
        tick();
        iack_i = 1'b0; idat_i = 32'd0;
        chk("f1_res_valid", 64'(insn_valid_o), 64'd1);
        chk("f1_insn",      64'(insn_o), 64'h13);
        chk("f1_err",       64'(insn_err_o), 64'd0);
        chk("f1_pc",        insn_pc_o, 64'h1000);
        chk("f1_istb_off",  64'(istb_o), 64'd0);
        tick();
        chk("f1_hold_valid", 64'(insn_valid_o), 64'd1);
        chk("f1_hold_insn",  64'(insn_o), 64'h13);
        insn_ready_i = 1'b1;
        tick();
        insn_ready_i = 1'b0;
        chk("f1_retired", 64'(insn_valid_o), 64'd0);

        // Misaligned request: no bus cycle, error code 11
        pc_i = 64'h1002; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        chk("mis_istb",  64'(istb_o), 64'd0);
        chk("mis_valid", 64'(insn_valid_o), 64'd1);
        chk("mis_err",   64'(insn_err_o), 64'd3);
        chk("mis_pc",    insn_pc_o, 64'h1002);
        chk("mis_insn",  64'(insn_o), 64'd0);
        // Stray ack outside BUS is ignored
        iack_i = 1'b1; idat_i = 32'hFFFF_FFFF;
        tick();
        iack_i = 1'b0; idat_i = 32'd0;
        chk("stray_err",  64'(insn_err_o), 64'd3);
        chk("stray_insn", 64'(insn_o), 64'd0);
        chk("stray_istb", 64'(istb_o), 64'd0);

        // Back-to-back: consume and accept 0x1004 in the same cycle
        insn_ready_i = 1'b1; pc_valid_i = 1'b1; pc_i = 64'h1004;
        #1;
        chk("b2b_ready", 64'(pc_ready_o), 64'd1);
        tick();
        insn_ready_i = 1'b0; pc_valid_i = 1'b0;
        chk("b2b_istb",  64'(istb_o), 64'd1);
        chk("b2b_iadr",  iadr_o, 64'h1004);
        chk("b2b_valid", 64'(insn_valid_o), 64'd0);

        // No ack: strobe high exactly TIMEOUT cycles, then timeout code
        n = 0;
        while (istb_o && n < 40) begin
            n++;
            if (iadr_o !== 64'h1004) chk("to_iadr_stable", iadr_o, 64'h1004);
            tick();
        end
        chk("to_strobe_cycles", 64'(n), 64'(TIMEOUT));
        chk("to_err",   64'(insn_err_o), 64'd2);
        chk("to_valid", 64'(insn_valid_o), 64'd1);
        chk("to_pc",    insn_pc_o, 64'h1004);
        insn_ready_i = 1'b1;
        tick();
        insn_ready_i = 1'b0;
        chk("to_retired", 64'(insn_valid_o), 64'd0);

        // Error and ack together in third BUS cycle: error wins
        pc_i = 64'h2000; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        tick();
        tick();
        chk("be_still_bus", 64'(istb_o), 64'd1);
        ierr_i = 1'b1; iack_i = 1'b1; idat_i = 32'hDEAD_BEEF;
        tick();
        ierr_i = 1'b0; iack_i = 1'b0; idat_i = 32'd0;
        chk("be_err",   64'(insn_err_o), 64'd1);
        chk("be_insn",  64'(insn_o), 64'd0);
        chk("be_valid", 64'(insn_valid_o), 64'd1);
        chk("be_istb",  64'(istb_o), 64'd0);

        // Flush in HOLD overrides ready and blocks a new request
        flush_i = 1'b1; insn_ready_i = 1'b1; pc_valid_i = 1'b1; pc_i = 64'h3000;
        #1;
        chk("fh_ready", 64'(pc_ready_o), 64'd0);
        tick();
        flush_i = 1'b0; insn_ready_i = 1'b0; pc_valid_i = 1'b0;
        chk("fh_valid", 64'(insn_valid_o), 64'd0);
        chk("fh_istb",  64'(istb_o), 64'd0);
        #1;
        chk("fh_idle_ready", 64'(pc_ready_o), 64'd1);

        // Flush in second BUS cycle with same-cycle ack: ack discarded
        pc_i = 64'h4000; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        tick();
        flush_i = 1'b1; iack_i = 1'b1; idat_i = 32'h55;
        tick();
        flush_i = 1'b0; iack_i = 1'b0; idat_i = 32'd0;
        chk("fb_istb",  64'(istb_o), 64'd0);
        chk("fb_valid", 64'(insn_valid_o), 64'd0);
        tick();
        chk("fb_valid_later", 64'(insn_valid_o), 64'd0);
        chk("fb_idle_ready",  64'(pc_ready_o), 64'd1);

        // Reset asserted mid-BUS
        pc_i = 64'h5000; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        chk("mr_istb_pre", 64'(istb_o), 64'd1);
        reset_ni = 1'b0;
        #1;
        chk("mr_ready_low", 64'(pc_ready_o), 64'd0);
        tick();
        chk("mr_istb",  64'(istb_o), 64'd0);
        chk("mr_valid", 64'(insn_valid_o), 64'd0);
        chk("mr_err",   64'(insn_err_o), 64'd0);
        chk("mr_iadr",  iadr_o, 64'd0);
        chk("mr_insn",  64'(insn_o), 64'd0);
        chk("mr_pc",    insn_pc_o, 64'd0);
        reset_ni = 1'b1;
        // Watchdog restarted: a fresh fetch still times out after TIMEOUT
        pc_i = 64'h6000; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        n = 0;
        while (istb_o && n < 40) begin
            n++;
            tick();
        end
        chk("mr_to_cycles", 64'(n), 64'(TIMEOUT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_initiator
`default_nettype wire
